// File: rtl/aoi_stream_fifo.sv
// -----------------------------------------------------------------------------
// aoi_stream_fifo
//
// Clocked, vector-wide successor to the three-input AOI logic cell. Every
// accepted operand triple {a, b, c} is evaluated once into
//   d = (a & b) | ~c
//   e = ~c
// and the {d, e} pair is buffered in a DEPTH-entry result FIFO. Both sides
// use valid/ready handshakes.
//
// Parameters:
//   WIDTH  operand/result vector width
//   DEPTH  result FIFO entries (power of two, >= 2)
//   CNT_W  width of the occupancy count output
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      source presents a valid a/b/c triple
//   in_ready      block can accept a triple this cycle (depends on state only)
//   a, b, c       operand vectors
//   out_valid     FIFO head holds a result
//   out_ready     consumer takes the head this cycle
//   d, e          head result, forced to zero while the FIFO is empty
//   count         number of stored results, 0..DEPTH
//   overflow_err  sticky flag: in_valid seen while full, cleared by reset only
//   ones_total    (only with AOI_STATS_EN) saturating sum of popcount(d) over
//                 every popped result
//
// Optional feature macro: AOI_STATS_EN
// -----------------------------------------------------------------------------
module aoi_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err
`ifdef AOI_STATS_EN
  ,
  output logic [31:0]      ones_total
`endif
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  // AOI evaluation of one operand triple; result packed as {d, e}.
  function automatic logic [2*WIDTH-1:0] aoi_eval(
    input logic [WIDTH-1:0] av,
    input logic [WIDTH-1:0] bv,
    input logic [WIDTH-1:0] cv
  );
    return {(av & bv) | ~cv, ~cv};
  endfunction

  // State registers and their next-state values
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  // Handshake qualifiers
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [2*WIDTH-1:0] head_s;

  // count is the single source of truth for full/empty; pointers just wrap.
  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == ZERO_CNT);
  // A push is refused while full even if a pop frees a slot on the same edge,
  // which keeps in_ready free of any path from out_ready.
  assign push_s  = in_valid & ~full_s;
  assign pop_s   = ~empty_s & out_ready;
  assign head_s  = mem_q[rd_ptr_q];

  // Next-state computation for pointers, occupancy and the sticky error flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    if (in_valid && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= ZERO_CNT;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Result storage; contents are don't-care after reset because reads are
  // gated by count, so no reset is applied here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= aoi_eval(a, b, c);
    end
  end

  // Status and head outputs derived from registered state only
  always_comb begin
    in_ready     = ~full_s;
    out_valid    = ~empty_s;
    count        = count_q;
    overflow_err = ovf_q;
    d            = {WIDTH{1'b0}};
    e            = {WIDTH{1'b0}};
    if (!empty_s) begin
      d = head_s[2*WIDTH-1:WIDTH];
      e = head_s[WIDTH-1:0];
    end else begin
      d = {WIDTH{1'b0}};
      e = {WIDTH{1'b0}};
    end
  end

`ifdef AOI_STATS_EN
  // Number of set bits in a result vector.
  function automatic logic [31:0] popcount(input logic [WIDTH-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  logic [31:0] ones_q, ones_d;
  logic [32:0] ones_sum_s;

  // Saturating accumulation of popcount(d) on every pop
  always_comb begin
    ones_sum_s = {1'b0, ones_q} + {1'b0, popcount(d)};
    ones_d     = ones_q;
    if (pop_s) begin
      if (ones_sum_s[32]) begin
        ones_d = 32'hFFFF_FFFF;
      end else begin
        ones_d = ones_sum_s[31:0];
      end
    end else begin
      ones_d = ones_q;
    end
  end

  // Statistics register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 32'd0;
    end else begin
      ones_q <= ones_d;
    end
  end

  assign ones_total = ones_q;
`endif

endmodule
